prog_seq_ctrl: RTL and testbench
================================

Name: prog_seq_ctrl

Overview:
- Program sequencer core that consumes the per-cycle flow-control controls (sync_reset, jmp, jmp_nz, dont_jmp, jmp_addr) driven through the sequencer input interface.
- Holds the program counter and produces the program-memory address every cycle.
- Adds a small hardware return-address stack for call/ret flow control.
- Sits between the instruction decoder/interface and program memory.

Parameters:
- ADDR_W, 4, width of jmp_addr, pc and pm_addr.
- STACK_DEPTH, 4, number of return-address entries (power of two, >= 2).

Ports:
- clk  input  1  single system clock, all state on rising edge
- sync_reset  input  1  synchronous, active-high reset
- jmp  input  1  unconditional jump to jmp_addr
- jmp_nz  input  1  conditional jump to jmp_addr unless dont_jmp
- dont_jmp  input  1  condition flag (zero result); suppresses jmp_nz when 1
- jmp_addr  input  ADDR_W  jump/call target
- call  input  1  push return address (pc+1), go to jmp_addr
- ret  input  1  pop return address into pc
- stall  input  1  hold pc and stack this cycle
- pc  output  ADDR_W  registered program counter
- pm_addr  output  ADDR_W  combinational next address to program memory
- stack_empty  output  1  no entries held
- stack_full  output  1  STACK_DEPTH entries held
- stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, sync_reset.
- Reset values: pc=0, stack pointer=0, stack_err=0, stack_empty=1, stack_full=0. While sync_reset=1, pm_addr=0 combinationally.
- pm_addr is the next pc, and pc <= pm_addr every cycle, so there is zero latency from control to pm_addr and one cycle to pc.
- Next-address priority, highest first:
  - sync_reset -> 0
  - stall -> pc (stack unchanged, all other controls ignored)
  - ret -> top of stack (pop)
  - call -> jmp_addr (push pc+1)
  - jmp -> jmp_addr
  - jmp_nz & ~dont_jmp -> jmp_addr
  - otherwise pc+1
- Simultaneous controls: a lower-priority control is ignored, with no side effects, when a higher one wins.
- Arithmetic: pc+1 is modulo 2^ADDR_W. pc=15 increments to 0, and push of pc=15 stores 0.
- jmp_nz & dont_jmp=1: no jump; increment.
- Stack: register array plus pointer sp in 0..STACK_DEPTH.
  - stack_empty = (sp==0); stack_full = (sp==STACK_DEPTH).
  - Push writes entry[sp], sp+1.
  - Pop reads entry[sp-1], sp-1.
- Overflow (call while full): jump still taken, push dropped, sp unchanged, stack_err<=1.
- Underflow (ret while empty): treated as increment, sp unchanged, stack_err<=1.
- stack_err is sticky and clears only on sync_reset.
- Reset mid-operation: sync_reset wins over every control in the same cycle. Stack contents need not clear; sp clears, so old entries are unreachable.
- Stack contents are not reset-required, but must never propagate X to pm_addr after reset.

Decomposition:
- Shared package prog_seq_pkg:
  - ADDR_W default constant
  - addr_t typedef (logic [ADDR_W-1:0])
  - enum next_sel_e {SEL_RST, SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_JNZ, SEL_INC}, used by the priority encoder and by bench coverage
- One sub-module: prog_seq_ret_stack, containing the LIFO with push/pop/full/empty/err. The top holds the priority select, pc register and pm_addr mux.

Test Plan:
- Reset then 17 idle cycles -> pm_addr 0,1,…,15,0; pc lags by one cycle; wrap 15->0 confirmed.
- pc=3, jmp=1, jmp_addr=9 -> pm_addr=9 same cycle, pc=9 next cycle. Then jmp_nz=1, dont_jmp=1, jmp_addr=2 -> pm_addr=10. Then dont_jmp=0 -> pm_addr=2.
- pc=5, call with jmp_addr=12 -> pc=12, stack_empty=0. Two idles -> pc 13,14. ret -> pm_addr=6, stack_empty=1.
- Five nested calls from pc=1,2,3,4,5 with STACK_DEPTH=4 -> stack_full after the 4th; 5th still jumps, stack_err=1. Four rets return 5,4,3,2. A fifth ret -> pc+1, stack_err stays 1 until sync_reset.
- Concurrency and hold:
  - jmp, call and ret together with a non-empty stack -> ret wins and only a pop occurs.
  - stall with call -> pc and sp unchanged.
- sync_reset asserted with call=1 at pc=7 -> pm_addr=0, pc=0, sp=0, stack_err=0 next cycle.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared definitions for the program sequencer.
//   DEF_ADDR_W      - default program-address width
//   DEF_STACK_DEPTH - default return-address stack depth
//   addr_t          - program address type at the default width
//   next_sel_e      - next-address source chosen by the priority encoder
package prog_seq_pkg;

    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_STACK_DEPTH = 4;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        SEL_RST  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_RET  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_JMP  = 3'd4,
        SEL_JNZ  = 3'd5,
        SEL_INC  = 3'd6
    } next_sel_e;

endpackage

// File: rtl/prog_seq_ret_stack.sv
// prog_seq_ret_stack: LIFO of return addresses for call/ret.
//   clk, sync_reset       - clock and synchronous active-high reset
//   push, pop             - one operation per cycle (push has priority)
//   push_data             - return address to store
//   top_data              - newest entry, forced to 0 while empty
//   empty, full           - occupancy flags derived from the pointer
//   err                   - sticky overflow/underflow flag
module prog_seq_ret_stack
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] entry_r [STACK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic              err_r;
    logic              empty_s;
    logic              full_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [ADDR_W-1:0] top_data_s;

    assign empty_s   = (sp_r == SP_W'(0));
    assign full_s    = (sp_r == SP_FULL);
    assign top_idx_s = sp_r[IDX_W-1:0] - IDX_W'(1);

    // Top-of-stack read; entries are never reset, so the empty case is
    // forced to zero to keep unwritten storage away from pm_addr.
    always_comb begin
        top_data_s = {ADDR_W{1'b0}};
        if (empty_s) begin
            top_data_s = {ADDR_W{1'b0}};
        end else begin
            top_data_s = entry_r[top_idx_s];
        end
    end

    // Stack pointer and sticky error; a rejected push/pop leaves sp alone.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sp_r  <= SP_W'(0);
            err_r <= 1'b0;
        end else if (push) begin
            if (full_s) begin
                err_r <= 1'b1;
            end else begin
                sp_r <= sp_r + SP_W'(1);
            end
        end else if (pop) begin
            if (empty_s) begin
                err_r <= 1'b1;
            end else begin
                sp_r <= sp_r - SP_W'(1);
            end
        end else begin
            sp_r  <= sp_r;
            err_r <= err_r;
        end
    end

    // Entry storage write; no reset needed because sp gates every read.
    always_ff @(posedge clk) begin
        if (!sync_reset && push && !full_s) begin
            entry_r[sp_r[IDX_W-1:0]] <= push_data;
        end
    end

    assign top_data = top_data_s;
    assign empty    = empty_s;
    assign full     = full_s;
    assign err      = err_r;

endmodule

// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl: program counter, next-address priority select and
// return-address stack for the program sequencer.
//   clk, sync_reset                - clock, synchronous active-high reset
//   jmp, jmp_nz, dont_jmp, jmp_addr - jump controls and target
//   call, ret                      - subroutine call / return
//   stall                          - hold pc and stack this cycle
//   pc                             - registered program counter
//   pm_addr                        - next address (combinational) to memory
//   stack_empty/full/err           - return stack status
module prog_seq_ctrl
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              call,
    input  logic              ret,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pm_addr,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] pm_addr_s;
    logic [ADDR_W-1:0] stack_top_s;
    logic              stack_empty_s;
    logic              push_s;
    logic              pop_s;
    next_sel_e         sel_s;

    assign pc_inc_s = pc_r + ADDR_W'(1);

    // Priority encoder; a ret on an empty stack falls back to increment
    // and swallows every lower-priority control.
    always_comb begin
        sel_s = SEL_INC;
        if (sync_reset) begin
            sel_s = SEL_RST;
        end else if (stall) begin
            sel_s = SEL_HOLD;
        end else if (ret) begin
            if (stack_empty_s) begin
                sel_s = SEL_INC;
            end else begin
                sel_s = SEL_RET;
            end
        end else if (call) begin
            sel_s = SEL_CALL;
        end else if (jmp) begin
            sel_s = SEL_JMP;
        end else if (jmp_nz && !dont_jmp) begin
            sel_s = SEL_JNZ;
        end else begin
            sel_s = SEL_INC;
        end
    end

    // Next-address mux feeding program memory directly.
    always_comb begin
        pm_addr_s = {ADDR_W{1'b0}};
        case (sel_s)
            SEL_RST:  pm_addr_s = {ADDR_W{1'b0}};
            SEL_HOLD: pm_addr_s = pc_r;
            SEL_RET:  pm_addr_s = stack_top_s;
            SEL_CALL: pm_addr_s = jmp_addr;
            SEL_JMP:  pm_addr_s = jmp_addr;
            SEL_JNZ:  pm_addr_s = jmp_addr;
            SEL_INC:  pm_addr_s = pc_inc_s;
            default:  pm_addr_s = {ADDR_W{1'b0}};
        endcase
    end

    // The stack sees a pop for any un-stalled ret so it can flag underflow;
    // a push is issued only when call actually wins (overflow flagged there).
    assign push_s = (sel_s == SEL_CALL);
    assign pop_s  = !sync_reset && !stall && ret;

    // Program counter follows pm_addr every cycle.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r <= pm_addr_s;
        end
    end

    prog_seq_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (push_s),
        .pop        (pop_s),
        .push_data  (pc_inc_s),
        .top_data   (stack_top_s),
        .empty      (stack_empty_s),
        .full       (stack_full),
        .err        (stack_err)
    );

    assign pc          = pc_r;
    assign pm_addr     = pm_addr_s;
    assign stack_empty = stack_empty_s;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// tb_prog_seq_ctrl: directed stimulus with hand-computed expectations
// queued per cycle; a monitor pops and compares at each falling edge.
module tb_prog_seq_ctrl;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       jmp, jmp_nz, dont_jmp, call, ret, stall;
    logic [3:0] jmp_addr;
    logic [3:0] pc, pm_addr;
    logic       stack_empty, stack_full, stack_err;

    typedef struct {
        int         id;
        logic [3:0] pm;
        logic [3:0] pc;
        logic       emp;
        logic       full;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    prog_seq_ctrl #(.ADDR_W(4), .STACK_DEPTH(4)) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .jmp_addr    (jmp_addr),
        .call        (call),
        .ret         (ret),
        .stall       (stall),
        .pc          (pc),
        .pm_addr     (pm_addr),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %0d expected %0d", id, nm, act, exp);
        end
    endtask

    // Apply one cycle of controls just after the rising edge and queue
    // what the DUT should show during that cycle.
    task automatic step(input logic sr, input logic j, input logic jnz, input logic dj,
                        input logic c, input logic r, input logic st, input logic [3:0] a,
                        input logic [3:0] e_pm, input logic [3:0] e_pc,
                        input logic e_emp, input logic e_full, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        sync_reset = sr; jmp = j; jmp_nz = jnz; dont_jmp = dj;
        call = c; ret = r; stall = st; jmp_addr = a;
        step_id++;
        e.id = step_id; e.pm = e_pm; e.pc = e_pc;
        e.emp = e_emp; e.full = e_full; e.err = e_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [3:0] e_pm, input logic [3:0] e_pc,
                        input logic e_emp, input logic e_full, input logic e_err);
        step(0, 0, 0, 0, 0, 0, 0, 4'd0, e_pm, e_pc, e_emp, e_full, e_err);
    endtask

    // Monitor: every cycle carries an output, compare when one is queued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pm_addr",     e.id, {4'd0, pm_addr},     {4'd0, e.pm});
                chk("pc",          e.id, {4'd0, pc},          {4'd0, e.pc});
                chk("stack_empty", e.id, {7'd0, stack_empty}, {7'd0, e.emp});
                chk("stack_full",  e.id, {7'd0, stack_full},  {7'd0, e.full});
                chk("stack_err",   e.id, {7'd0, stack_err},   {7'd0, e.err});
            end
        end
    end

    initial begin
        sync_reset = 1'b1; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
        call = 1'b0; ret = 1'b0; stall = 1'b0; jmp_addr = 4'd0;
        repeat (2) @(posedge clk);

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0, 4'd0, 1, 0, 0);
        // free-running increment with wrap 15 -> 0
        for (int i = 0; i < 16; i++) idle(4'((i + 1) % 16), 4'(i), 1, 0, 0);

        // jumps:       sr j jnz dj c r st addr   pm  pc  emp full err
        step(0, 1, 0, 0, 0, 0, 0, 4'd3,  4'd3,  4'd0,  1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 4'd9,  4'd9,  4'd3,  1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 4'd2,  4'd10, 4'd9,  1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 4'd2,  4'd2,  4'd10, 1, 0, 0);

        // single call / ret
        step(0, 1, 0, 0, 0, 0, 0, 4'd5,  4'd5,  4'd2,  1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd12, 4'd12, 4'd5,  1, 0, 0);
        idle(4'd13, 4'd12, 0, 0, 0);
        idle(4'd14, 4'd13, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd6,  4'd14, 0, 0, 0);
        idle(4'd7, 4'd6, 1, 0, 0);

        // nested calls, overflow, rets, underflow
        step(0, 1, 0, 0, 0, 0, 0, 4'd1,  4'd1,  4'd7,  1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd2,  4'd2,  4'd1,  1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd3,  4'd3,  4'd2,  0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd4,  4'd4,  4'd3,  0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd5,  4'd5,  4'd4,  0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd8,  4'd8,  4'd5,  0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd5,  4'd8,  0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd4,  4'd5,  0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd3,  4'd4,  0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd2,  4'd3,  0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd3,  4'd2,  1, 0, 1);
        idle(4'd4, 4'd3, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 4'd0,  4'd0,  4'd4,  1, 0, 1);
        idle(4'd1, 4'd0, 1, 0, 0);

        // jmp+call+ret with non-empty stack: only the pop happens
        step(0, 0, 0, 0, 1, 0, 0, 4'd10, 4'd10, 4'd1,  1, 0, 0);
        step(0, 1, 0, 0, 1, 1, 0, 4'd7,  4'd2,  4'd10, 0, 0, 0);
        idle(4'd3, 4'd2, 1, 0, 0);

        // stall with call holds pc and sp
        step(0, 0, 0, 0, 1, 0, 1, 4'd9,  4'd3,  4'd3,  1, 0, 0);
        idle(4'd4, 4'd3, 1, 0, 0);

        // underflow sets err, then reset with call at pc=7 clears it
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd5,  4'd4,  1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 4'd6,  4'd6,  4'd5,  1, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0, 4'd7,  4'd7,  4'd6,  0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 0, 4'd12, 4'd0,  4'd7,  0, 0, 1);
        idle(4'd1, 4'd0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 4'd0,  4'd2,  4'd1,  1, 0, 0);
        idle(4'd3, 4'd2, 1, 0, 1);

        // bounded drain of the scoreboard
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        chk("queue_drain", step_id, 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
